// File: rtl/blit_engine_if.sv
// ============================================================================
// Module      : blit_engine_if
// Description : Command-FIFO and framebuffer write-port bundle of the blitter
//               command stage. The engine side uses the master modport, the
//               FIFO/framebuffer side uses the slave modport.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface blit_engine_if;
    logic [103:0] cmd;
    logic         cmd_valid;
    logic         cmd_next;
    logic         pix_valid;
    logic         pix_ready;
    logic [31:0]  pix_addr;
    logic [7:0]   pix_data;
    logic         busy;
    logic         err;

    modport master (
        input  cmd, cmd_valid, pix_ready,
        output cmd_next, pix_valid, pix_addr, pix_data, busy, err
    );

    modport slave (
        output cmd, cmd_valid, pix_ready,
        input  cmd_next, pix_valid, pix_addr, pix_data, busy, err
    );
endinterface

`default_nettype wire

// File: rtl/blit_engine.sv
// ============================================================================
// Module      : blit_engine
// Description : Pops 104-bit blit commands, keeps the destination surface
//               state and walks FILL rectangles, issuing one byte-wide pixel
//               write per accepted cycle.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module blit_engine (
    input  wire logic     clock,
    input  wire logic     reset,
    blit_engine_if.master bus
);

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_DECODE   = 2'd1;
    localparam logic [1:0] c_ST_FILL     = 2'd2;

    localparam logic [3:0] c_OP_NOP      = 4'd0;
    localparam logic [3:0] c_OP_SET_DEST = 4'd1;
    localparam logic [3:0] c_OP_FILL     = 4'd2;

    logic [1:0]   r_state;
    logic [103:0] r_cmd;
    logic [31:0]  r_dest_base;
    logic [15:0]  r_dest_stride;
    logic [31:0]  r_row_addr;
    logic [31:0]  r_cur_addr;
    logic [15:0]  r_xcnt;
    logic [15:0]  r_ycnt;
    logic [7:0]   r_colour;
    logic         r_err;

    // Field views of the latched command.
    logic [3:0]  w_op;
    logic [15:0] w_x;
    logic [15:0] w_y;
    logic [15:0] w_w;
    logic [15:0] w_h;
    logic [31:0] w_base;
    logic [15:0] w_stride;
    logic [31:0] w_row_start;
    logic        w_x_last;
    logic        w_y_last;

    assign w_op     = r_cmd[103:100];
    assign w_x      = r_cmd[95:80];
    assign w_y      = r_cmd[79:64];
    assign w_w      = r_cmd[63:48];
    assign w_h      = r_cmd[47:32];
    assign w_base   = r_cmd[63:32];
    assign w_stride = r_cmd[15:0];

    // First pixel of the rectangle; everything wraps modulo 2^32.
    assign w_row_start = r_dest_base
                       + ({16'd0, w_y} * {16'd0, r_dest_stride})
                       + {16'd0, w_x};

    assign w_x_last = (r_xcnt == w_w - 16'd1);
    assign w_y_last = (r_ycnt == w_h - 16'd1);

    // The pop strobe is gated by reset so the FIFO is never popped while held.
    assign bus.cmd_next  = (r_state == c_ST_IDLE) && bus.cmd_valid && reset;
    assign bus.pix_valid = (r_state == c_ST_FILL);
    assign bus.pix_addr  = r_cur_addr;
    assign bus.pix_data  = r_colour;
    assign bus.busy      = (r_state != c_ST_IDLE) || bus.cmd_valid;
    assign bus.err       = r_err;

    // Command sequencing, surface state and rectangle walk.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= c_ST_IDLE;
            r_cmd         <= '0;
            r_dest_base   <= '0;
            r_dest_stride <= '0;
            r_row_addr    <= '0;
            r_cur_addr    <= '0;
            r_xcnt        <= '0;
            r_ycnt        <= '0;
            r_colour      <= '0;
            r_err         <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        r_cmd   <= bus.cmd;
                        r_state <= c_ST_DECODE;
                    end
                end
                c_ST_DECODE: begin
                    r_state <= c_ST_IDLE;
                    case (w_op)
                        c_OP_NOP: ;
                        c_OP_SET_DEST: begin
                            r_dest_base   <= w_base;
                            r_dest_stride <= w_stride;
                        end
                        c_OP_FILL: begin
                            if ((w_w != 16'd0) && (w_h != 16'd0)) begin
                                r_row_addr <= w_row_start;
                                r_cur_addr <= w_row_start;
                                r_xcnt     <= '0;
                                r_ycnt     <= '0;
                                r_colour   <= r_cmd[7:0];
                                r_state    <= c_ST_FILL;
                            end
                        end
                        default: r_err <= 1'b1;
                    endcase
                end
                c_ST_FILL: begin
                    if (bus.pix_ready) begin
                        if (!w_x_last) begin
                            r_cur_addr <= r_cur_addr + 32'd1;
                            r_xcnt     <= r_xcnt + 16'd1;
                        end else if (!w_y_last) begin
                            // Next row starts one stride below the previous row start.
                            r_row_addr <= r_row_addr + {16'd0, r_dest_stride};
                            r_cur_addr <= r_row_addr + {16'd0, r_dest_stride};
                            r_xcnt     <= '0;
                            r_ycnt     <= r_ycnt + 16'd1;
                        end else begin
                            r_state <= c_ST_IDLE;
                        end
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_blit_engine.sv
// ============================================================================
// Module      : tb_blit_engine
// Description : Self-checking bench for blit_engine. A queue models the
//               command FIFO; a rectangle-level reference model predicts the
//               pixel stream, surface state and error flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_blit_engine;

    logic clock;
    logic reset;

    blit_engine_if bif ();

    blit_engine dut (
        .clock (clock),
        .reset (reset),
        .bus   (bif.master)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Environment and reference model state.
    logic [103:0] fifo[$];
    logic [39:0]  exp_q[$];       // {addr, data}
    logic [31:0]  m_base;
    logic [15:0]  m_stride;
    logic         m_err;

    int n_cmp;
    int n_fail;
    int n_pops;
    int n_acc;
    int busy_cyc;
    int ready_mode;
    int ready_phase;
    logic        last_busy;
    logic        prev_stall;
    logic [31:0] prev_addr;
    logic [7:0]  prev_data;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, expv);
        end
    endtask

    function automatic logic [103:0] f_fill(input logic [15:0] x, input logic [15:0] y,
                                            input logic [15:0] w, input logic [15:0] h,
                                            input logic [7:0] col);
        return {4'd2, 4'd0, x, y, w, h, 24'd0, col};
    endfunction

    function automatic logic [103:0] f_dest(input logic [31:0] base, input logic [15:0] stride);
        return {4'd1, 4'd0, 32'd0, base, 16'd0, stride};
    endfunction

    task automatic drive_fifo();
        bif.cmd_valid = (fifo.size() != 0);
        bif.cmd       = (fifo.size() != 0) ? fifo[0] : '0;
    endtask

    // Queue a command and apply its architectural effect to the model.
    task automatic push_cmd(input logic [103:0] c);
        logic [3:0]  op;
        logic [15:0] x, y, w, h;
        logic [31:0] a;
        op = c[103:100];
        x = c[95:80]; y = c[79:64]; w = c[63:48]; h = c[47:32];
        if (op == 4'd1) begin
            m_base   = c[63:32];
            m_stride = c[15:0];
        end else if (op == 4'd2) begin
            for (int j = 0; j < int'(h); j++)
                for (int i = 0; i < int'(w); i++) begin
                    a = m_base + (32'(y) + 32'(j)) * 32'(m_stride) + 32'(x) + 32'(i);
                    exp_q.push_back({a, c[7:0]});
                end
        end else if (op != 4'd0) begin
            m_err = 1'b1;
        end
        fifo.push_back(c);
        drive_fifo();
    endtask

    // One clock: observe at the falling edge, update inputs just after the rising edge.
    task automatic tick();
        logic pop_now;
        @(negedge clock);
        last_busy = bif.busy;
        if (bif.busy) busy_cyc++;
        if (prev_stall) begin
            check("hold_valid", {31'd0, bif.pix_valid}, 32'd1);
            check("hold_addr", bif.pix_addr, prev_addr);
            check("hold_data", {24'd0, bif.pix_data}, {24'd0, prev_data});
        end
        if (bif.pix_valid && bif.pix_ready) begin
            n_acc++;
            if (exp_q.size() == 0) begin
                check("extra_pixel", bif.pix_addr, 32'hFFFF_FFFF ^ bif.pix_addr);
            end else begin
                check("pix_addr", bif.pix_addr, exp_q[0][39:8]);
                check("pix_data", {24'd0, bif.pix_data}, {24'd0, exp_q[0][7:0]});
                void'(exp_q.pop_front());
            end
        end
        prev_stall = bif.pix_valid && !bif.pix_ready;
        prev_addr  = bif.pix_addr;
        prev_data  = bif.pix_data;
        pop_now    = bif.cmd_next;
        if (pop_now) begin
            n_pops++;
            if (fifo.size() == 0) check("pop_empty", 32'd1, 32'd0);
        end
        @(posedge clock);
        #1;
        if (pop_now && fifo.size() != 0) void'(fifo.pop_front());
        drive_fifo();
        ready_phase++;
        case (ready_mode)
            0:       bif.pix_ready = 1'b1;
            1:       bif.pix_ready = ((ready_phase % 3) == 0);
            default: bif.pix_ready = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic drain(input int budget, input string tag);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((last_busy || fifo.size() != 0) && n < budget);
        check({tag, "_timeout"}, {31'd0, (last_busy || fifo.size() != 0)}, 32'd0);
        check({tag, "_left"}, exp_q.size(), 32'd0);
        check({tag, "_err"}, {31'd0, bif.err}, {31'd0, m_err});
    endtask

    initial begin
        int p0, a0, k;
        n_cmp = 0; n_fail = 0; n_pops = 0; n_acc = 0; busy_cyc = 0;
        ready_mode = 0; ready_phase = 0;
        prev_stall = 1'b0; prev_addr = '0; prev_data = '0; last_busy = 1'b0;
        m_base = '0; m_stride = '0; m_err = 1'b0;
        bif.pix_ready = 1'b1;
        drive_fifo();

        // Reset values.
        reset = 1'b1;
        #1 reset = 1'b0;
        #12;
        check("rst_cmd_next", {31'd0, bif.cmd_next}, 32'd0);
        check("rst_pix_valid", {31'd0, bif.pix_valid}, 32'd0);
        check("rst_pix_addr", bif.pix_addr, 32'd0);
        check("rst_pix_data", {24'd0, bif.pix_data}, 32'd0);
        check("rst_err", {31'd0, bif.err}, 32'd0);
        check("rst_busy", {31'd0, bif.busy}, 32'd0);
        @(posedge clock); #3 reset = 1'b1;
        p0 = n_pops;
        for (int i = 0; i < 3; i++) tick();
        check("post_rst_pops", n_pops - p0, 32'd0);
        check("post_rst_valid", {31'd0, bif.pix_valid}, 32'd0);

        // Basic fill: 2 + 2 + 6 busy cycles, no row-end bubble.
        p0 = n_pops; busy_cyc = 0;
        push_cmd(f_dest(32'h0000_1000, 16'd320));
        push_cmd(f_fill(16'd2, 16'd3, 16'd3, 16'd2, 8'h5A));
        drain(100, "basic");
        check("basic_pops", n_pops - p0, 32'd2);
        check("basic_cycles", busy_cyc, 32'd10);
        check("basic_last_addr", bif.pix_addr, 32'h0000_1504);

        // Backpressure with ready pattern 1,0,0.
        ready_mode = 1; ready_phase = 0; a0 = n_acc;
        push_cmd(f_fill(16'd2, 16'd3, 16'd3, 16'd2, 8'h5A));
        drain(200, "bp");
        check("bp_count", n_acc - a0, 32'd6);
        ready_mode = 0;

        // Degenerate rectangles and illegal opcode.
        p0 = n_pops; a0 = n_acc;
        push_cmd(f_fill(16'd0, 16'd0, 16'd0, 16'd5, 8'h11));
        push_cmd(f_fill(16'd0, 16'd0, 16'd4, 16'd0, 8'h22));
        push_cmd({4'd7, 100'd0});
        drain(100, "degen");
        check("degen_pops", n_pops - p0, 32'd3);
        check("degen_pixels", n_acc - a0, 32'd0);
        for (int i = 0; i < 4; i++) tick();
        check("err_sticky", {31'd0, bif.err}, 32'd1);

        // Wrap-around past 0xFFFFFFFF.
        push_cmd(f_dest(32'hFFFF_FFFE, 16'd0));
        push_cmd(f_fill(16'd0, 16'd0, 16'd4, 16'd1, 8'hA5));
        drain(100, "wrap");
        check("wrap_last_addr", bif.pix_addr, 32'h0000_0001);

        // Randomized command mix against the model.
        ready_mode = 2;
        for (int it = 0; it < 150; it++) begin
            k = $urandom_range(0, 9);
            if (k <= 1)
                push_cmd(f_dest($urandom, 16'($urandom_range(0, 600))));
            else if (k <= 7)
                push_cmd(f_fill(16'($urandom), 16'($urandom), 16'($urandom_range(0, 4)),
                                16'($urandom_range(0, 4)), 8'($urandom)));
            else if (k == 8)
                push_cmd({4'd0, 4'($urandom), 96'd0});
            else
                push_cmd({4'($urandom_range(3, 15)), 100'd0});
            if ($urandom_range(0, 3) == 0) drain(3000, "rand");
        end
        drain(3000, "rand_final");
        ready_mode = 0;

        // Reset during the 3rd pixel of a 4x4 fill.
        push_cmd(f_dest(32'h0000_2000, 16'd16));
        push_cmd(f_fill(16'd0, 16'd0, 16'd4, 16'd4, 8'h77));
        a0 = n_acc; k = 0;
        while (n_acc < a0 + 2 && k < 100) begin
            tick();
            k++;
        end
        check("mid_reached", {31'd0, (n_acc >= a0 + 2)}, 32'd1);
        #2 reset = 1'b0;
        #1;
        check("mid_pix_valid", {31'd0, bif.pix_valid}, 32'd0);
        check("mid_cmd_next", {31'd0, bif.cmd_next}, 32'd0);
        check("mid_err", {31'd0, bif.err}, 32'd0);
        fifo.delete(); exp_q.delete();
        m_base = '0; m_stride = '0; m_err = 1'b0;
        prev_stall = 1'b0;
        drive_fifo();
        tick();
        #3 reset = 1'b1;
        push_cmd(f_fill(16'd1, 16'd1, 16'd1, 16'd1, 8'hC3));
        drain(100, "after_rst");
        check("after_rst_addr", bif.pix_addr, 32'h0000_0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
